// File: rtl/hangman_game_ctrl_pkg.sv
// Shared constants for the hangman controller: keyboard codes, game phase
// encoding and the scancode-to-letter-index helper.
package hangman_pkg;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSL  = 8'h5D;
  localparam logic [4:0] SC_IDX_NONE = 5'd31;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    GUESS = 3'd2,
    CHECK = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } phase_e;

  // Set-2 scancodes of A..Z map to 0..25; anything else maps to 31.
  function automatic logic [4:0] sc_to_idx(input logic [7:0] sc);
    case (sc)
      8'h1C: return 5'd0;   8'h32: return 5'd1;   8'h21: return 5'd2;
      8'h23: return 5'd3;   8'h24: return 5'd4;   8'h2B: return 5'd5;
      8'h34: return 5'd6;   8'h33: return 5'd7;   8'h43: return 5'd8;
      8'h3B: return 5'd9;   8'h42: return 5'd10;  8'h4B: return 5'd11;
      8'h3A: return 5'd12;  8'h31: return 5'd13;  8'h44: return 5'd14;
      8'h4D: return 5'd15;  8'h15: return 5'd16;  8'h2D: return 5'd17;
      8'h1B: return 5'd18;  8'h2C: return 5'd19;  8'h3C: return 5'd20;
      8'h2A: return 5'd21;  8'h1D: return 5'd22;  8'h22: return 5'd23;
      8'h35: return 5'd24;  8'h1A: return 5'd25;
      default: return SC_IDX_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hangman_game_ctrl_if.sv
// Controller <-> letter-store datapath link.
// Protocol: store_en, cmp_en and clr are single-cycle pulses with no
// backpressure; store_idx/store_code and cmp_code are valid while their
// strobe is high. The datapath answers a cmp_en pulse with hit/all_found
// valid in the cycle immediately after the pulse.
interface hangman_game_ctrl_if;
  logic       store_en;
  logic [3:0] store_idx;
  logic [7:0] store_code;
  logic       cmp_en;
  logic [7:0] cmp_code;
  logic       hit;
  logic       all_found;
  logic       clr;

  modport master (output store_en, store_idx, store_code, cmp_en, cmp_code, clr,
                  input  hit, all_found);
  modport slave  (input  store_en, store_idx, store_code, cmp_en, cmp_code, clr,
                  output hit, all_found);
endinterface

// File: rtl/hangman_game_ctrl_key_event_detect.sv
// Registers the raw scancode and produces a one-cycle event on each
// zero -> nonzero transition, together with the key class.
module key_event_detect
  import hangman_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scancode,
  output logic       key_evt,
  output logic [7:0] key_code,
  output logic       is_enter,
  output logic       is_bksl,
  output logic       is_letter
);

  logic [7:0] sc_q, sc_d;
  logic [7:0] sc_prev_q, sc_prev_d;

  // Next values: sample the keyboard, keep one cycle of history.
  always_comb begin
    sc_d      = scancode;
    sc_prev_d = sc_q;
  end

  // Scancode pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q      <= 8'h00;
      sc_prev_q <= 8'h00;
    end else begin
      sc_q      <= sc_d;
      sc_prev_q <= sc_prev_d;
    end
  end

  assign key_evt   = (sc_q != 8'h00) && (sc_prev_q == 8'h00);
  assign key_code  = sc_q;
  assign is_enter  = (sc_q == SC_ENTER);
  assign is_bksl   = (sc_q == SC_BKSL);
  assign is_letter = !is_enter && !is_bksl;

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game-phase sequencer: key events in, store/compare/clear strobes
// out, miss counting and LED status. Optional macro DUP_GUESS_FILTER_EN
// suppresses compares for letters already guessed in the current game.
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int MAX_LEN  = 10,
  parameter int MAX_MISS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           scancode,
  hangman_game_ctrl_if.master  bus,
  output logic [2:0]           phase,
  output logic [3:0]           misses,
  output logic [3:0]           word_len,
  output logic [7:0]           led
);

  logic       key_evt, is_enter, is_bksl, is_letter;
  logic [7:0] key_code;

  key_event_detect u_key (
    .clk(clk), .rst(rst), .scancode(scancode),
    .key_evt(key_evt), .key_code(key_code),
    .is_enter(is_enter), .is_bksl(is_bksl), .is_letter(is_letter)
  );

  phase_e     state_q, state_d;
  logic [7:0] cur_code_q, cur_code_d;
  logic       cur_valid_q, cur_valid_d;
  logic [3:0] word_len_q, word_len_d;
  logic [3:0] misses_q, misses_d;
  logic       store_en_q, store_en_d;
  logic [3:0] store_idx_q, store_idx_d;
  logic [7:0] store_code_q, store_code_d;
  logic       cmp_en_q, cmp_en_d;
  logic [7:0] cmp_code_q, cmp_code_d;
  logic       clr_q, clr_d;
  logic [7:0] led_q, led_d;
`ifdef DUP_GUESS_FILTER_EN
  logic [25:0] guessed_q, guessed_d;
  logic [4:0]  cur_idx;
`endif

  // Next-state and registered-output logic for the game flow.
  always_comb begin
    state_d      = state_q;
    cur_code_d   = cur_code_q;
    cur_valid_d  = cur_valid_q;
    word_len_d   = word_len_q;
    misses_d     = misses_q;
    store_en_d   = 1'b0;
    store_idx_d  = store_idx_q;
    store_code_d = store_code_q;
    cmp_en_d     = 1'b0;
    cmp_code_d   = cmp_code_q;
    clr_d        = 1'b0;
    led_d        = 8'h00;
`ifdef DUP_GUESS_FILTER_EN
    guessed_d    = guessed_q;
    cur_idx      = sc_to_idx(cur_code_q);
`endif
    case (state_q)
      IDLE: begin
        clr_d       = 1'b1;
        word_len_d  = 4'd0;
        misses_d    = 4'd0;
        cur_valid_d = 1'b0;
        cur_code_d  = 8'h00;
`ifdef DUP_GUESS_FILTER_EN
        guessed_d   = '0;
`endif
        state_d     = ENTRY;
      end
      ENTRY: begin
        if (key_evt) begin
          if (is_letter) begin
            cur_code_d  = key_code;
            cur_valid_d = 1'b1;
          end else if (is_enter && cur_valid_q) begin
            store_en_d   = 1'b1;
            store_idx_d  = word_len_q;
            store_code_d = cur_code_q;
            word_len_d   = word_len_q + 4'd1;
            cur_valid_d  = 1'b0;
            if (word_len_q + 4'd1 == 4'(MAX_LEN)) state_d = GUESS;
          end else if (is_bksl && word_len_q != 4'd0) begin
            cur_valid_d = 1'b0;
            state_d     = GUESS;
          end
        end
      end
      GUESS: begin
        // The cycle carrying cmp_en leads into the single CHECK cycle, where
        // the datapath answer is valid.
        if (cmp_en_q) begin
          state_d = CHECK;
        end else if (key_evt) begin
          if (is_letter) begin
            cur_code_d  = key_code;
            cur_valid_d = 1'b1;
          end else if (is_enter && cur_valid_q) begin
            cur_valid_d = 1'b0;
`ifdef DUP_GUESS_FILTER_EN
            if (cur_idx == SC_IDX_NONE || !guessed_q[cur_idx]) begin
              if (cur_idx != SC_IDX_NONE) guessed_d[cur_idx] = 1'b1;
              cmp_en_d   = 1'b1;
              cmp_code_d = cur_code_q;
            end
`else
            cmp_en_d   = 1'b1;
            cmp_code_d = cur_code_q;
`endif
          end
        end
      end
      CHECK: begin
        if (bus.hit) begin
          state_d = bus.all_found ? WIN : GUESS;
        end else begin
          if (misses_q != 4'(MAX_MISS)) misses_d = misses_q + 4'd1;
          state_d = (misses_q + 4'd1 == 4'(MAX_MISS)) ? LOSE : GUESS;
        end
      end
      WIN, LOSE: begin
        if (key_evt && is_enter) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      ENTRY:        led_d = cur_code_d;
      GUESS, CHECK: led_d = {4'b0000, misses_d};
      WIN:          led_d = 8'hFF;
      LOSE:         led_d = 8'(MAX_MISS);
      default:      led_d = 8'h00;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_code_q   <= 8'h00;
      cur_valid_q  <= 1'b0;
      word_len_q   <= 4'd0;
      misses_q     <= 4'd0;
      store_en_q   <= 1'b0;
      store_idx_q  <= 4'd0;
      store_code_q <= 8'h00;
      cmp_en_q     <= 1'b0;
      cmp_code_q   <= 8'h00;
      clr_q        <= 1'b0;
      led_q        <= 8'h00;
`ifdef DUP_GUESS_FILTER_EN
      guessed_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_code_q   <= cur_code_d;
      cur_valid_q  <= cur_valid_d;
      word_len_q   <= word_len_d;
      misses_q     <= misses_d;
      store_en_q   <= store_en_d;
      store_idx_q  <= store_idx_d;
      store_code_q <= store_code_d;
      cmp_en_q     <= cmp_en_d;
      cmp_code_q   <= cmp_code_d;
      clr_q        <= clr_d;
      led_q        <= led_d;
`ifdef DUP_GUESS_FILTER_EN
      guessed_q    <= guessed_d;
`endif
    end
  end

  assign bus.store_en   = store_en_q;
  assign bus.store_idx  = store_idx_q;
  assign bus.store_code = store_code_q;
  assign bus.cmp_en     = cmp_en_q;
  assign bus.cmp_code   = cmp_code_q;
  assign bus.clr        = clr_q;
  assign phase          = state_q;
  assign misses         = misses_q;
  assign word_len       = word_len_q;
  assign led            = led_q;

endmodule
